// File: rtl/mmu_pager_if.sv
// CPU-side bus bundle for the memory pager: strobes, address, data and
// the pager's decoded outputs. The pager sits on the slave modport.
interface mmu_pager_if #(
  parameter int PAGE_BITS = 3,
  parameter int BANK_W    = 3
);
  logic                 rd;
  logic                 wr;
  logic                 mreq;
  logic                 iorq;
  logic [7:0]           a07;
  logic [PAGE_BITS-1:0] a_hi;
  logic [7:0]           data_in;
  logic [7:0]           data_out;
  logic                 data_oe;
  logic [BANK_W-1:0]    bank;
  logic                 romen;
  logic                 ramen;
  logic                 wp_fault;

  modport master (
    output rd, wr, mreq, iorq, a07, a_hi, data_in,
    input  data_out, data_oe, bank, romen, ramen, wp_fault
  );

  modport slave (
    input  rd, wr, mreq, iorq, a07, a_hi, data_in,
    output data_out, data_oe, bank, romen, ramen, wp_fault
  );
endinterface

// File: rtl/mmu_pager.sv
// Memory pager: maps the top PAGE_BITS CPU address bits onto bank numbers
// through I/O-programmable page registers, with per-page write protection,
// a sticky protection-fault flag and a key-sequence lock on the registers.
module mmu_pager #(
  parameter int         PAGE_BITS = 3,
  parameter int         BANK_W    = 3,
  parameter logic [7:0] IO_BASE   = 8'hC0
) (
  input  logic        clk,
  input  logic        reset,
  mmu_pager_if.slave  bus
);

  localparam int NPAGES = 1 << PAGE_BITS;

  localparam logic [1:0] ST_UNLOCKED = 2'b00;
  localparam logic [1:0] ST_LOCKED   = 2'b01;
  localparam logic [1:0] ST_KEY1     = 2'b10;

  // Synchroniser chains for the asynchronous CPU strobes ([1] is the safe tap)
  logic [1:0] r_rd_sync;
  logic [1:0] r_wr_sync;
  logic [1:0] r_mreq_sync;
  logic [1:0] r_iorq_sync;
  logic       r_wr_prev;
  // Fills with ones after reset; an edge only counts once r_wr_prev holds a
  // genuinely sampled strobe value rather than the reset preset.
  logic [2:0] r_warm;

  logic [1:0] r_lock;
  logic [1:0] w_lock_next;
  logic       r_fault;

  logic [NPAGES-1:0][BANK_W-1:0] w_page;
  logic [NPAGES-1:0]             w_wp;
  logic [15:0]                   w_wp16;

  logic                 w_rd_s, w_wr_s, w_mreq_s, w_iorq_s;
  logic                 w_wr_fall, w_io_ev, w_mem_ev;
  logic                 w_hit;
  logic [4:0]           w_off;
  logic [PAGE_BITS-1:0] w_pg_idx;
  logic                 w_unlocked;
  logic                 w_page_we, w_wpl_we, w_wph_we, w_ctl_we;
  logic [6:0]           w_key;
  logic [7:0]           w_rdata;
  logic [BANK_W-1:0]    w_bank;

  // Strobe synchronisers, previous-sample tracker and warm-up shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_sync   <= 2'b11;
      r_wr_sync   <= 2'b11;
      r_mreq_sync <= 2'b11;
      r_iorq_sync <= 2'b11;
      r_wr_prev   <= 1'b1;
      r_warm      <= 3'b000;
    end else begin
      r_rd_sync   <= {r_rd_sync[0],   bus.rd};
      r_wr_sync   <= {r_wr_sync[0],   bus.wr};
      r_mreq_sync <= {r_mreq_sync[0], bus.mreq};
      r_iorq_sync <= {r_iorq_sync[0], bus.iorq};
      r_wr_prev   <= r_wr_sync[1];
      r_warm      <= {r_warm[1:0], 1'b1};
    end
  end

  assign w_rd_s   = r_rd_sync[1];
  assign w_wr_s   = r_wr_sync[1];
  assign w_mreq_s = r_mreq_sync[1];
  assign w_iorq_s = r_iorq_sync[1];

  // A cycle with rd and wr both low is bus contention, not a valid write.
  assign w_wr_fall = r_warm[2] & r_wr_prev & ~w_wr_s & w_rd_s;

  // Address decode; a07/data_in are taken directly at the event edge
  assign w_hit      = (bus.a07[7:5] == IO_BASE[7:5]);
  assign w_off      = bus.a07[4:0];
  assign w_pg_idx   = bus.a07[PAGE_BITS-1:0];
  assign w_io_ev    = w_wr_fall & ~w_iorq_s & w_hit;
  assign w_mem_ev   = w_wr_fall & ~w_mreq_s;
  assign w_unlocked = (r_lock == ST_UNLOCKED);
  assign w_page_we  = w_io_ev & ~w_off[4] & w_unlocked;
  assign w_wpl_we   = w_io_ev & (w_off == 5'h10) & w_unlocked;
  assign w_wph_we   = w_io_ev & (w_off == 5'h11) & w_unlocked;
  assign w_ctl_we   = w_io_ev & (w_off == 5'h12);
  assign w_key      = bus.data_in[6:0];

  genvar gi;
  generate
    for (gi = 0; gi < NPAGES; gi++) begin : g_page
      logic [BANK_W-1:0] r_page;
      logic              r_wp;

      // Page register: page 0 boots to bank 0, every other page to bank 1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_page <= (gi == 0) ? '0 : BANK_W'(1);
        else if (w_page_we && (w_pg_idx == PAGE_BITS'(gi)))
          r_page <= bus.data_in[BANK_W-1:0];
      end

      // Write-protect bit: pages 0-7 live in the low mask byte, 8-15 in the high
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          r_wp <= 1'b0;
        else if ((gi < 8) ? w_wpl_we : w_wph_we)
          r_wp <= bus.data_in[gi % 8];
      end

      assign w_page[gi] = r_page;
      assign w_wp[gi]   = r_wp;
    end
  endgenerate

  assign w_wp16 = 16'(w_wp);

  // Lock FSM: unlock needs the 0x55, 0x2A pair; a wrong second key relocks
  always_comb begin
    w_lock_next = r_lock;
    if (w_ctl_we) begin
      case (r_lock)
        ST_UNLOCKED: if (w_key == 7'h4C) w_lock_next = ST_LOCKED;
        ST_LOCKED:   if (w_key == 7'h55) w_lock_next = ST_KEY1;
        ST_KEY1:     w_lock_next = (w_key == 7'h2A) ? ST_UNLOCKED : ST_LOCKED;
        default:     w_lock_next = ST_LOCKED;
      endcase
    end
  end

  // Lock state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_lock <= ST_UNLOCKED;
    else
      r_lock <= w_lock_next;
  end

  // Sticky protection fault; a new violation beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_fault <= 1'b0;
    else if (w_mem_ev && w_wp[bus.a_hi])
      r_fault <= 1'b1;
    else if (w_ctl_we && bus.data_in[7])
      r_fault <= 1'b0;
  end

  // Combinational readback mux; reads never modify state
  always_comb begin
    w_rdata = 8'h00;
    if (!w_off[4]) begin
      w_rdata = 8'(w_page[w_pg_idx]);
    end else begin
      case (w_off)
        5'h10:   w_rdata = w_wp16[7:0];
        5'h11:   w_rdata = w_wp16[15:8];
        5'h12:   w_rdata = {r_fault, 5'b00000, r_lock};
        default: w_rdata = 8'h00;
      endcase
    end
  end

  assign w_bank       = w_page[bus.a_hi];
  assign bus.bank     = w_bank;
  assign bus.data_out = w_rdata;
  assign bus.data_oe  = ~bus.iorq & w_hit & ~bus.rd;
  assign bus.romen    = bus.mreq | w_bank[0];
  assign bus.ramen    = bus.mreq | ~w_bank[0] | (w_wp[bus.a_hi] & ~bus.wr);
  assign bus.wp_fault = r_fault;

endmodule

// File: tb/tb_mmu_pager.sv
// Directed bench for mmu_pager: a default (PAGE_BITS=3) instance and a
// PAGE_BITS=2 instance share the same stimulus; the second one is only
// inspected for page-index aliasing.
`timescale 1ns/1ps
module tb_mmu_pager;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd = 1'b1, wr = 1'b1, mreq = 1'b1, iorq = 1'b1;
  logic [7:0] a07 = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [2:0] a_hi = 3'd0;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mmu_pager_if #(.PAGE_BITS(3), .BANK_W(3)) bus ();
  mmu_pager_if #(.PAGE_BITS(2), .BANK_W(3)) bus2 ();

  assign bus.rd = rd;       assign bus2.rd = rd;
  assign bus.wr = wr;       assign bus2.wr = wr;
  assign bus.mreq = mreq;   assign bus2.mreq = mreq;
  assign bus.iorq = iorq;   assign bus2.iorq = iorq;
  assign bus.a07 = a07;     assign bus2.a07 = a07;
  assign bus.data_in = data_in; assign bus2.data_in = data_in;
  assign bus.a_hi = a_hi;   assign bus2.a_hi = a_hi[1:0];

  mmu_pager #(.PAGE_BITS(3), .BANK_W(3), .IO_BASE(8'hC0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mmu_pager #(.PAGE_BITS(2), .BANK_W(3), .IO_BASE(8'hC0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  task automatic io_write(input logic [7:0] addr, input logic [7:0] dat);
    a07 = addr; data_in = dat; iorq = 1'b0; wr = 1'b0;
    repeat (5) @(negedge clk);
    wr = 1'b1; iorq = 1'b1;
    repeat (3) @(negedge clk);
    a07 = 8'h00;
    $display("OUT %h <- %h", addr, dat);
  endtask

  task automatic mem_write(input logic [2:0] page, output logic ramen_pre,
                           output logic ramen_low);
    a_hi = page; mreq = 1'b0;
    #1 ramen_pre = bus.ramen;
    wr = 1'b0;
    #1 ramen_low = bus.ramen;
    repeat (5) @(negedge clk);
    wr = 1'b1; mreq = 1'b1;
    repeat (3) @(negedge clk);
    $display("MEMWR page %0d", page);
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] d,
                         output logic [7:0] d2, output logic oe);
    a07 = addr; iorq = 1'b0; rd = 1'b0;
    #1;
    d = bus.data_out; d2 = bus2.data_out; oe = bus.data_oe;
    rd = 1'b1; iorq = 1'b1;
    @(negedge clk);
    $display("IN  %h -> %h (oe=%0b)", addr, d, oe);
  endtask

  task automatic test_reset();
    logic [7:0] d, d2; logic oe;
    #2 reset = 1'b0;
    #1;
    n_chk++; if (bus.romen !== 1'b1) begin n_fail++; $display("FAIL reset_romen: got %b expected 1", bus.romen); end
    n_chk++; if (bus.ramen !== 1'b1) begin n_fail++; $display("FAIL reset_ramen: got %b expected 1", bus.ramen); end
    n_chk++; if (bus.data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", bus.data_oe); end
    n_chk++; if (bus.wp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.wp_fault); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", d); end
    io_read(8'hC1, d, d2, oe);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL reset_page1: got %h expected 01", d); end
  endtask

  task automatic test_bank_decode();
    mreq = 1'b0; a_hi = 3'd0;
    #1;
    n_chk++; if (bus.bank !== 3'd0) begin n_fail++; $display("FAIL bank_p0: got %0d expected 0", bus.bank); end
    n_chk++; if (bus.romen !== 1'b0) begin n_fail++; $display("FAIL romen_p0: got %b expected 0", bus.romen); end
    n_chk++; if (bus.ramen !== 1'b1) begin n_fail++; $display("FAIL ramen_p0: got %b expected 1", bus.ramen); end
    a_hi = 3'd5;
    #1;
    n_chk++; if (bus.bank !== 3'd1) begin n_fail++; $display("FAIL bank_p5: got %0d expected 1", bus.bank); end
    n_chk++; if (bus.romen !== 1'b1) begin n_fail++; $display("FAIL romen_p5: got %b expected 1", bus.romen); end
    n_chk++; if (bus.ramen !== 1'b0) begin n_fail++; $display("FAIL ramen_p5: got %b expected 0", bus.ramen); end
    mreq = 1'b1; a_hi = 3'd0;
    @(negedge clk);
  endtask

  task automatic test_page_regs();
    logic [7:0] d, d2; logic oe;
    io_write(8'hC3, 8'h06);
    io_write(8'hC7, 8'h05);
    io_read(8'hC3, d, d2, oe);
    n_chk++; if (d !== 8'h06) begin n_fail++; $display("FAIL page3_rd: got %h expected 06", d); end
    n_chk++; if (oe !== 1'b1) begin n_fail++; $display("FAIL page3_oe: got %b expected 1", oe); end
    n_chk++; if (d2 !== 8'h05) begin n_fail++; $display("FAIL alias_pb2: got %h expected 05", d2); end
    io_read(8'hC7, d, d2, oe);
    n_chk++; if (d !== 8'h05) begin n_fail++; $display("FAIL page7_rd: got %h expected 05", d); end
    a_hi = 3'd3;
    #1;
    n_chk++; if (bus.bank !== 3'd6) begin n_fail++; $display("FAIL bank_p3: got %0d expected 6", bus.bank); end
    a_hi = 3'd0;
    io_read(8'h40, d, d2, oe);
    n_chk++; if (oe !== 1'b0) begin n_fail++; $display("FAIL miss_oe: got %b expected 0", oe); end
    io_read(8'hD5, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL reserved_rd: got %h expected 00", d); end
    io_write(8'hD1, 8'hFF);
    io_read(8'hD1, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL wp_hi_rd: got %h expected 00", d); end
  endtask

  task automatic test_lock();
    logic [7:0] d, d2; logic oe;
    io_write(8'hD2, 8'h4C);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL lock_status: got %h expected 01", d); end
    io_write(8'hC1, 8'h07);
    io_read(8'hC1, d, d2, oe);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL locked_page1: got %h expected 01", d); end
    io_write(8'hD2, 8'h55);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h02) begin n_fail++; $display("FAIL key1_status: got %h expected 02", d); end
    io_write(8'hD2, 8'h2A);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL unlock_status: got %h expected 00", d); end
    io_write(8'hC1, 8'h07);
    io_read(8'hC1, d, d2, oe);
    n_chk++; if (d !== 8'h07) begin n_fail++; $display("FAIL unlocked_page1: got %h expected 07", d); end
    io_write(8'hD2, 8'h4C);
    io_write(8'hD2, 8'h55);
    io_write(8'hD2, 8'h11);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL badkey_status: got %h expected 01", d); end
    io_write(8'hD2, 8'h55);
    io_write(8'hD2, 8'h2A);
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL reunlock_status: got %h expected 00", d); end
  endtask

  task automatic test_wp_fault();
    logic [7:0] d, d2; logic oe, rp, rl;
    io_write(8'hD0, 8'h20);
    mem_write(3'd5, rp, rl);
    n_chk++; if (rp !== 1'b0) begin n_fail++; $display("FAIL ramen_pre: got %b expected 0", rp); end
    n_chk++; if (rl !== 1'b1) begin n_fail++; $display("FAIL ramen_wp: got %b expected 1", rl); end
    n_chk++; if (bus.wp_fault !== 1'b1) begin n_fail++; $display("FAIL fault_set: got %b expected 1", bus.wp_fault); end
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h80) begin n_fail++; $display("FAIL fault_status: got %h expected 80", d); end
    io_write(8'hD2, 8'h80);
    n_chk++; if (bus.wp_fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", bus.wp_fault); end
    mem_write(3'd3, rp, rl);
    n_chk++; if (bus.wp_fault !== 1'b0) begin n_fail++; $display("FAIL unprot_write: got %b expected 0", bus.wp_fault); end
    a_hi = 3'd5; a07 = 8'hD2; data_in = 8'h80;
    mreq = 1'b0; iorq = 1'b0; wr = 1'b0;
    repeat (5) @(negedge clk);
    wr = 1'b1; mreq = 1'b1; iorq = 1'b1;
    repeat (3) @(negedge clk);
    a07 = 8'h00; a_hi = 3'd0;
    $display("OUT d2 <- 80 with MEMWR page 5");
    n_chk++; if (bus.wp_fault !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b expected 1", bus.wp_fault); end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d, d2; logic oe;
    a07 = 8'hC2; data_in = 8'h05; iorq = 1'b0; wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (bus.wp_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", bus.wp_fault); end
    a_hi = 3'd1; #1;
    n_chk++; if (bus.bank !== 3'd1) begin n_fail++; $display("FAIL rst_bank1: got %0d expected 1", bus.bank); end
    a_hi = 3'd3; #1;
    n_chk++; if (bus.bank !== 3'd1) begin n_fail++; $display("FAIL rst_bank3: got %0d expected 1", bus.bank); end
    a_hi = 3'd0; #1;
    n_chk++; if (bus.bank !== 3'd0) begin n_fail++; $display("FAIL rst_bank0: got %0d expected 0", bus.bank); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    wr = 1'b1; iorq = 1'b1;
    repeat (3) @(negedge clk);
    a07 = 8'h00;
    $display("OUT c2 <- 05 interrupted by reset");
    io_read(8'hC2, d, d2, oe);
    n_chk++; if (d !== 8'h01) begin n_fail++; $display("FAIL held_strobe: got %h expected 01", d); end
    io_read(8'hD0, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_wpmask: got %h expected 00", d); end
    io_read(8'hD2, d, d2, oe);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_status: got %h expected 00", d); end
    io_write(8'hC2, 8'h05);
    io_read(8'hC2, d, d2, oe);
    n_chk++; if (d !== 8'h05) begin n_fail++; $display("FAIL post_rst_write: got %h expected 05", d); end
  endtask

  initial begin
    test_reset();
    test_bank_decode();
    test_page_regs();
    test_lock();
    test_wp_fault();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmu_pager.md
MMU_PAGER -- requirements
Module: mmu_pager

Interface
REQ-001 SHALL have parameter PAGE_BITS, default 3, number of CPU address bits used as page index (2^PAGE_BITS pages, legal 1..4).
REQ-002 SHALL have parameter BANK_W, default 3, page-register width (legal 1..8).
REQ-003 SHALL have parameter IO_BASE, default 8'hC0, I/O window base, 32-aligned.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 rd, wr, mreq, iorq  in  1 each  CPU strobes, active-low, asynchronous to clk.
REQ-007 a07  in  8  CPU address bits 7:0 (I/O decode).
REQ-008 a_hi  in  PAGE_BITS  CPU address bits 15 down to 16-PAGE_BITS (page index).
REQ-009 data_in  in  8  CPU data bus, input side.
REQ-010 data_out  out  8  readback data; data_oe  out  1  high drives bus.
REQ-011 bank  out  BANK_W  bank number of the currently addressed page.
REQ-012 romen, ramen  out  1 each  active-low memory enables.
REQ-013 wp_fault  out  1  sticky write-protect violation flag.

Function
REQ-014 Window: iorq low and a07[7:5]==IO_BASE[7:5]; offset = a07[4:0].
REQ-015 Offsets 0x00-0x0F: page register a07[PAGE_BITS-1:0] (higher index bits ignored, aliases); 0x10: WP mask low byte; 0x11: WP mask high byte (unused bits read 0, writes ignored); 0x12: control/status; others: write ignored, read 8'h00.
REQ-016 rd, wr, mreq, iorq SHALL pass through 2-flop synchronisers; a write event = synchronised wr falling edge with synchronised iorq low (I/O) or mreq low (memory).
REQ-017 On an I/O write event, addressed register SHALL update at the same clk edge the event is detected (3rd clk edge after wr falls, +/-1 for metastability); a07 and data_in sampled at that edge.
REQ-018 Readback combinational: data_oe = window hit and rd low (unsynchronised); data_out = zero-extended register, status = {wp_fault, 5'b0, lock_state[1:0]}.
REQ-019 bank = page_reg[a_hi], combinational.
REQ-020 romen = mreq or bank[0]; ramen = mreq or ~bank[0] or (wp[a_hi] and ~wr).
REQ-021 Lock FSM states UNLOCKED (2'b00), LOCKED (2'b01), KEY1 (2'b10); moves only on control writes (offset 0x12), data_in[6:0] = key.
REQ-022 UNLOCKED: key 0x4C -> LOCKED; other -> stay.
REQ-023 LOCKED: key 0x55 -> KEY1; other -> stay.
REQ-024 KEY1: key 0x2A -> UNLOCKED; any other key -> LOCKED.
REQ-025 Page and WP register writes SHALL take effect only in UNLOCKED; ignored in LOCKED/KEY1 without state change.
REQ-026 Control write with data_in[7]=1 SHALL clear wp_fault in any state, in addition to key processing.
REQ-027 Memory write event while wp[a_hi]=1 SHALL set wp_fault next edge; set wins over simultaneous clear.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 reset low SHALL immediately force: page_reg[0]=0, page_reg[1..N-1]=1, WP mask=0, wp_fault=0, FSM=UNLOCKED, synchronisers to idle (high), no pending event.
REQ-030 Reset mid-write SHALL discard that write; strobe held low across reset release SHALL NOT produce an event (edge requires prior high sample).
REQ-031 Outputs after reset (defaults, mreq high): romen=1, ramen=1, data_oe=0, wp_fault=0.

Verification
REQ-032 Reset, mreq low, a_hi=0 -> bank=0, romen=0, ramen=1; a_hi=5 -> bank=1, romen=1, ramen=0.
REQ-033 OUT 0xC3 <- 0x06, IN 0xC3 -> 0x06; a_hi=3 -> bank=6; PAGE_BITS=2 bench: OUT 0xC7 aliases page 3.
REQ-034 OUT 0xD2 <- 0x4C; OUT 0xC1 <- 0x07 -> page1 stays 1, status 0x01; OUT 0xD2 0x55, 0x2A -> status 0x00, write then accepted; 0x55,0x11 -> status 0x01.
REQ-035 OUT 0xD0 <- 0x20, memory write to page 5 -> ramen stays 1, wp_fault=1, status 0x80; OUT 0xD2 <- 0x80 -> fault cleared; same-cycle fault and clear -> wp_fault=1.
REQ-036 Assert reset during wr low with page write pending -> all registers at REQ-029 values, no update after release.
